// File: rtl/common.sv
`default_nettype none
// ============================================================================
//  Module      : common (package)
//  Description : Data-bus transaction types shared between the pipeline's
//                memory stage and its memory-side responders.
//  Types       : msize_t     - access size (1, 2 or 4 bytes)
//                dbus_req_t  - valid, addr, size, strobe, data
//                dbus_resp_t - addr_ok, data_ok, data
//  Revision    : 1.0 - initial release
// ============================================================================
package common;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2
    } msize_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        msize_t      size;
        logic [3:0]  strobe;
        logic [31:0] data;
    } dbus_req_t;

    typedef struct packed {
        logic        addr_ok;
        logic        data_ok;
        logic [31:0] data;
    } dbus_resp_t;

endpackage
`default_nettype wire

// File: rtl/dbus_resp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dbus_resp_pkg (package)
//  Description : FSM state type, latency counter width and the alignment
//                helper used by the data-bus SRAM responder.
//  Revision    : 1.0 - initial release
// ============================================================================
package dbus_resp_pkg;
    import common::*;

    // Latency counter width; holds LATENCY-2 for LATENCY up to 15.
    localparam int c_LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dresp_state_t;

    // Halfwords must be 2-byte aligned, words 4-byte aligned; bytes never fault.
    function automatic logic isMisaligned(input msize_t size, input logic [1:0] addrLo);
        case (size)
            MSIZE2:  return addrLo[0];
            MSIZE4:  return |addrLo;
            default: return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram_1rw_be.sv
`default_nettype none
// ============================================================================
//  Module      : sram_1rw_be
//  Description : Single-port synchronous SRAM, 32-bit words, per-byte write
//                enables, registered read. Write-first: on a write the read
//                register receives the merged (post-write) word.
//  Ports       : clk     - clock
//                i_en    - access enable; read register only loads when set
//                i_we    - byte-lane write enables
//                i_addr  - word index
//                i_wdata - lane-aligned write data
//                o_rdata - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_1rw_be #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [3:0]        i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] w_merged;

    // Old word with the enabled lanes replaced, so a write returns new data.
    always_comb begin
        w_merged = r_mem[i_addr];
        for (int b = 0; b < 4; b++) begin
            if (i_we[b]) begin
                w_merged[8*b +: 8] = i_wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            o_rdata <= w_merged;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dbus_sram_resp.sv
`default_nettype none
// ============================================================================
//  Module      : dbus_sram_resp
//  Description : Memory-side data-bus responder backed by a word-addressed
//                SRAM. Accepts one request at a time and answers with
//                data_ok a fixed LATENCY cycles after addr_ok.
//  Ports       : clk       - clock
//                reset     - synchronous, active-high reset
//                dreq      - request from the memory stage
//                dresp     - addr_ok / data_ok / data response
//                err       - sticky: bad (out-of-range/misaligned) request seen
//                req_count - requests accepted since reset (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module dbus_sram_resp
    import common::*;
    import dbus_resp_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          LATENCY     = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  dbus_req_t   dreq,
    output dbus_resp_t  dresp,
    output logic        err,
    output logic [31:0] req_count
);

    localparam int                     c_IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0]            c_SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
    localparam logic [c_LAT_CNT_W-1:0] c_WAIT_LOAD  =
        (LATENCY >= 2) ? c_LAT_CNT_W'(LATENCY - 2) : '0;

    dresp_state_t           r_state;
    dresp_state_t           w_nextState;
    logic [c_LAT_CNT_W-1:0] r_cnt;
    logic [c_LAT_CNT_W-1:0] w_nextCnt;
    logic                   r_bad;
    logic                   r_err;
    logic [31:0]            r_reqCount;

    logic                   w_accept;
    logic [31:0]            w_offset;
    logic                   w_inRange;
    logic                   w_bad;
    logic [c_IDX_W-1:0]     w_index;
    logic [3:0]             w_ramWe;
    logic [31:0]            w_ramRdata;
    logic                   w_dataOk;
    logic [31:0]            w_respData;

    // Reset gates the handshake so nothing is accepted or answered while held.
    assign w_accept = (r_state == IDLE) && dreq.valid && !reset;

    // Addresses below BASE_ADDR wrap to huge offsets and fail the range test,
    // so a single unsigned compare covers both ends.
    assign w_offset  = dreq.addr - BASE_ADDR;
    assign w_inRange = {1'b0, w_offset} < c_SPAN_BYTES;
    assign w_bad     = !w_inRange || isMisaligned(dreq.size, dreq.addr[1:0]);
    assign w_index   = w_offset[c_IDX_W+1:2];
    assign w_ramWe   = (w_accept && !w_bad) ? dreq.strobe : 4'b0000;

    // The SRAM read register is the captured word: it only loads on accept,
    // so it stays stable through WAIT until RESP.
    sram_1rw_be #(
        .DEPTH  (DEPTH_WORDS),
        .ADDR_W (c_IDX_W)
    ) u_sram (
        .clk     (clk),
        .i_en    (w_accept),
        .i_we    (w_ramWe),
        .i_addr  (w_index),
        .i_wdata (dreq.data),
        .o_rdata (w_ramRdata)
    );

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (dreq.valid) begin
                    if (LATENCY == 1) begin
                        w_nextState = RESP;
                    end else begin
                        w_nextState = WAIT;
                        w_nextCnt   = c_WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_nextState = RESP;
                end else begin
                    w_nextCnt = r_cnt - c_LAT_CNT_W'(1);
                end
            end
            RESP:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_bad      <= 1'b0;
            r_err      <= 1'b0;
            r_reqCount <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            if (w_accept) begin
                r_bad      <= w_bad;
                r_reqCount <= r_reqCount + 32'd1;
                if (w_bad) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign w_dataOk   = (r_state == RESP) && !reset;
    assign w_respData = (w_dataOk && !r_bad) ? w_ramRdata : 32'h0;

    assign dresp     = '{addr_ok: w_accept, data_ok: w_dataOk, data: w_respData};
    assign err       = r_err;
    assign req_count = r_reqCount;

endmodule
`default_nettype wire
